// File: rtl/fetch_queue_ctrl_if.sv
// Fetch queue controller bus: start/redirect control, imem handshake,
// queue storage pointers and occupancy status.
interface fetch_queue_ctrl_if #(
    parameter int unsigned AW  = 3,
    parameter int unsigned PCW = 32
);
    logic           start;
    logic           redirect;
    logic [PCW-1:0] redirect_pc;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_gnt;
    logic           imem_rvalid;
    logic           wr_en;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           deq;
    logic           deq_valid;
    logic [AW:0]    count;
    logic           full;
    logic           empty;

    modport master (
        input  start, redirect, redirect_pc, imem_gnt, imem_rvalid, deq,
        output imem_req, imem_addr, wr_en, wr_ptr, rd_ptr, deq_valid, count, full, empty
    );

    modport slave (
        output start, redirect, redirect_pc, imem_gnt, imem_rvalid, deq,
        input  imem_req, imem_addr, wr_en, wr_ptr, rd_ptr, deq_valid, count, full, empty
    );
endinterface

// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch queue sequencer: one-outstanding imem fetches, fetch PC,
// queue pointers/occupancy; redirect flushes the queue and drops in-flight data.
module fetch_queue_ctrl #(
    parameter int unsigned    DEPTH  = 8,
    parameter int unsigned    AW     = $clog2(DEPTH),
    parameter int unsigned    PCW    = 32,
    parameter int unsigned    INC    = 4,
    parameter logic [PCW-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_queue_ctrl_if.master bus
);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e         state_q;
    logic [PCW-1:0] pc_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    logic full_c;
    logic empty_c;
    logic req_c;
    logic wr_c;
    logic deq_c;

    // Status decodes straight from the occupancy register.
    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

    // Never request into a full queue; a response is only written in WAIT.
    assign req_c = (state_q == S_REQ) && !full_c && !bus.redirect;
    assign wr_c  = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    assign deq_c = bus.deq && !empty_c && !bus.redirect;

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = pc_q;
    assign bus.wr_en     = wr_c;
    assign bus.wr_ptr    = wr_ptr_q;
    assign bus.rd_ptr    = rd_ptr_q;
    assign bus.count     = count_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.deq_valid = !empty_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RST_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.redirect) begin
            pc_q     <= bus.redirect_pc;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // An outstanding response must still be absorbed before re-requesting.
            case (state_q)
                S_WAIT, S_FLUSH: state_q <= bus.imem_rvalid ? S_REQ : S_FLUSH;
                default:         state_q <= state_q;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) state_q <= S_REQ;
                end
                S_REQ: begin
                    if (req_c && bus.imem_gnt) begin
                        pc_q    <= pc_q + PCW'(INC);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT, S_FLUSH: begin
                    if (bus.imem_rvalid) state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase

            if (wr_c)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (deq_c) rd_ptr_q <= rd_ptr_q + AW'(1);

            if (wr_c && !deq_c) begin
                count_q <= count_q + CW'(1);
            end else if (!wr_c && deq_c) begin
                count_q <= count_q - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Scoreboard bench for fetch_queue_ctrl: a transaction-level model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_fetch_queue_ctrl;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned PCW    = 32;
    localparam int unsigned INC    = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_ctrl_if #(.AW(AW), .PCW(PCW)) bus ();

    fetch_queue_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PCW   (PCW),
        .INC   (INC),
        .RST_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        wr_en;
        int          wr_ptr;
        int          rd_ptr;
        int          count;
        logic        full;
        logic        empty;
        logic        dv;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: a started flag, an outstanding fetch (possibly stale),
    // a fetch PC, an entry count and running totals of writes/reads.
    bit          m_valid   = 0;
    bit          m_started = 0;
    bit          m_infl    = 0;
    bit          m_stale   = 0;
    logic [31:0] m_pc      = '0;
    int          m_cnt     = 0;
    int          m_wr      = 0;
    int          m_rd      = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        else n_pass++;
    endfunction

    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] rpc,
                        input bit g, input bit rv, input bit dq);
        exp_t e;
        bit   req_e, wr_e, dq_acc;
        @(posedge clk);
        #1;
        rst             = r;
        bus.start       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.deq         = dq;

        req_e = m_started && !m_infl && (m_cnt < DEPTH) && !rd;
        wr_e  = m_infl && !m_stale && rv && !rd;
        if (m_valid) begin
            e.req    = req_e;
            e.addr   = m_pc;
            e.wr_en  = wr_e;
            e.wr_ptr = m_wr % DEPTH;
            e.rd_ptr = m_rd % DEPTH;
            e.count  = m_cnt;
            e.full   = (m_cnt == DEPTH);
            e.empty  = (m_cnt == 0);
            e.dv     = (m_cnt != 0);
            exp_q.push_back(e);
        end

        if (r) begin
            m_valid = 1; m_started = 0; m_infl = 0; m_stale = 0;
            m_pc = RST_PC; m_cnt = 0; m_wr = 0; m_rd = 0;
        end else if (rd) begin
            m_pc = rpc; m_cnt = 0; m_wr = 0; m_rd = 0;
            if (m_infl) begin
                if (rv) begin m_infl = 0; m_stale = 0; end
                else m_stale = 1;
            end
        end else begin
            if (!m_started && st) m_started = 1;
            if (req_e && g) begin
                m_pc   = m_pc + INC;
                m_infl = 1;
            end else if (m_infl && rv) begin
                m_infl  = 0;
                m_stale = 0;
            end
            dq_acc = dq && (m_cnt > 0);
            if (wr_e && !dq_acc) m_cnt++;
            else if (!wr_e && dq_acc) m_cnt--;
            if (wr_e) m_wr++;
            if (dq_acc) m_rd++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_req",  64'(bus.imem_req),  64'(e.req));
            chk("imem_addr", 64'(bus.imem_addr), 64'(e.addr));
            chk("wr_en",     64'(bus.wr_en),     64'(e.wr_en));
            chk("wr_ptr",    64'(bus.wr_ptr),    64'(e.wr_ptr));
            chk("rd_ptr",    64'(bus.rd_ptr),    64'(e.rd_ptr));
            chk("count",     64'(bus.count),     64'(e.count));
            chk("full",      64'(bus.full),      64'(e.full));
            chk("empty",     64'(bus.empty),     64'(e.empty));
            chk("deq_valid", 64'(bus.deq_valid), 64'(e.dv));
        end
    end

    initial begin
        int guard;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.deq         = 1'b0;

        step(1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        step(0, 0, 0, '0, 0, 0, 0);

        // Fill: grant every request, respond one cycle later, no dequeues.
        step(0, 1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 22; i++) step(0, 0, 0, '0, 1, m_infl, 0);

        // Single dequeue from full, then writes coinciding with dequeues.
        step(0, 0, 0, '0, 1, m_infl, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, m_infl, m_infl);

        // Redirect while waiting, stale response three cycles later.
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, 0, 1);
        guard = 0;
        while (!m_infl && guard < 10) begin step(0, 0, 0, '0, 1, 0, 0); guard++; end
        step(0, 0, 1, 32'h100, 1, 0, 0);
        step(0, 0, 0, '0, 1, 0, 0);
        step(0, 0, 0, '0, 1, 0, 0);
        step(0, 0, 0, '0, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1, m_infl, 0);

        // Redirect coincident with the response.
        guard = 0;
        while (!m_infl && guard < 10) begin step(0, 0, 0, '0, 1, 0, 0); guard++; end
        step(0, 0, 1, 32'h200, 1, 1, 0);
        step(0, 0, 0, '0, 0, 0, 0);

        // Dequeue attempts on an empty queue.
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, 0, 1);

        // Reset while waiting with five entries, then a late response.
        guard = 0;
        while (!(m_cnt >= 5 && m_infl) && guard < 40) begin
            step(0, 0, 0, '0, 1, m_infl, 0);
            guard++;
        end
        step(1, 0, 0, '0, 1, 0, 0);
        step(0, 0, 0, '0, 1, 1, 0);
        step(0, 0, 0, '0, 1, 1, 0);
        step(0, 1, 0, '0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(199) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(15) == 0), 32'($urandom),
                 ($urandom_range(1) == 1), m_infl && ($urandom_range(1) == 1),
                 ($urandom_range(2) != 0));
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_queue_ctrl.md
Name: fetch_queue_ctrl

Overview:
Sequencing controller for the instruction fetch queue. Issues one-outstanding fetch requests to instruction memory and owns the fetch PC, which increments on grant and loads on redirect. Maintains the queue write/read pointers and occupancy, and drives the storage array's write enable. A redirect (branch/flush) empties the queue and discards any in-flight response.

Parameters:
DEPTH, 8, queue entries; power of 2, >= 2
AW, $clog2(DEPTH), pointer width
PCW, 32, fetch PC width
INC, 4, PC increment per granted fetch
RST_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  leave IDLE and begin fetching
redirect  in  1  flush queue, load redirect_pc
redirect_pc  in  PCW  new fetch PC
imem_req  out  1  fetch request valid
imem_addr  out  PCW  fetch address (current PC register)
imem_gnt  in  1  request accepted this cycle (valid only with imem_req)
imem_rvalid  in  1  fetch data returned this cycle
wr_en  out  1  write returned data into queue[wr_ptr]
wr_ptr  out  AW  queue write index
rd_ptr  out  AW  queue read index (head for decode)
deq  in  1  decode consumes head entry
deq_valid  out  1  queue non-empty
count  out  AW+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst=1 at edge): state IDLE, pc=RST_PC, wr_ptr=rd_ptr=0, count=0; outputs imem_req=0, wr_en=0, deq_valid=0, full=0, empty=1. rst overrides every other input, including mid-request; a response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, FLUSH.
- IDLE: imem_req=0; start -> REQ.
- REQ: imem_req = !full && !redirect (combinational). imem_req && imem_gnt -> pc <= pc+INC (mod 2^PCW); state -> WAIT.
- WAIT: on imem_rvalid, wr_en=1 in the same cycle (combinational); wr_ptr increments at the edge; state -> REQ. At most one request outstanding; imem_req=0 in WAIT.
- FLUSH: waits for the stale response; imem_rvalid -> discarded (wr_en=0), state -> REQ.
- redirect (priority below rst, above everything else), effective at the next edge:
  - Clears wr_ptr, rd_ptr and count; pc <= redirect_pc.
  - deq and write are ignored in the redirect cycle; wr_en=0 whenever redirect=1.
  - IDLE stays IDLE; REQ stays REQ, and any grant that cycle is impossible because imem_req is masked.
  - WAIT without imem_rvalid -> FLUSH; WAIT with imem_rvalid the same cycle -> REQ, data dropped.
  - FLUSH stays FLUSH (pc reloaded again); FLUSH with imem_rvalid -> REQ.
- Pointers: wrap DEPTH-1 -> 0. rd_ptr increments on deq && !empty && !redirect. deq when empty has no effect.
- Occupancy: count +1 on write only, -1 on accepted deq only, unchanged on both same cycle.
- Full/empty: full, empty and deq_valid decode from count. Requests are issued only when !full, so a write never overflows. A request granted at count==DEPTH-1 whose response lands while a deq also fires leaves count unchanged.
- start is ignored outside IDLE. Once started, the controller never returns to IDLE except by rst.

Test Plan:
- Reset, start, gnt every req, rvalid 1 cycle after gnt, no deq -> imem_addr 0,4,...,28; wr_ptr 0..7 then wraps to 0; count reaches 8; full=1; imem_req=0 thereafter.
- Full queue, assert deq one cycle -> count 7, rd_ptr 1, imem_req re-asserts next cycle at addr 32; write plus deq in the same cycle keeps count 7.
- WAIT with redirect=1, redirect_pc=0x100, rvalid 3 cycles later -> FLUSH; that rvalid gives wr_en=0; count=0; next imem_addr 0x100.
- Redirect coincident with rvalid in WAIT -> wr_en=0, state REQ, count=0, imem_addr = redirect_pc.
- deq on empty queue for 3 cycles -> rd_ptr and count unchanged, deq_valid=0.
- rst asserted in WAIT with count=5 -> next cycle IDLE, count 0, pc RST_PC; a late rvalid causes no write.
